// File: rtl/syn_branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer.
//
// Purpose:
//   - Ties the default PC width to the instruction-memory address width.
//   - Supplies the default BTB geometry.
//   - Provides the counter initialisation helpers used by the BTB.
// Ports: none (package).
package syn_branch_target_buffer_pkg;

    localparam int IM_ADDR_BIT    = 10;
    localparam int BTB_ADDR_BITS  = IM_ADDR_BIT;
    localparam int BTB_INDEX_BITS = 4;
    localparam int BTB_CTR_BITS   = 2;

    // Weakly not-taken: one below the taken threshold (0 for a 1-bit counter).
    function automatic int unsigned ctr_weak_nt(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    // Weakly taken: the smallest value whose MSB is set.
    function automatic int unsigned ctr_weak_t(input int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/syn_branch_target_buffer_if.sv
// Pipeline <-> BTB connection bundle.
//
// Purpose: groups the IF-stage lookup and the EX-stage update signals.
// Ports (signals):
//   lk_pc, lk_hit, lk_taken, lk_next_pc            IF lookup
//   upd_valid, upd_is_jump, upd_pc, upd_taken,
//   upd_target, upd_pred_taken, upd_pred_next,
//   upd_mispredict                                 EX update / redirect
// Modports: master = pipeline side, slave = BTB side.
interface syn_branch_target_buffer_if
    import syn_branch_target_buffer_pkg::*;
#(
    parameter int ADDR_BITS = BTB_ADDR_BITS
) ();

    logic [ADDR_BITS-1:0] lk_pc;
    logic                 lk_hit;
    logic                 lk_taken;
    logic [ADDR_BITS-1:0] lk_next_pc;

    logic                 upd_valid;
    logic                 upd_is_jump;
    logic [ADDR_BITS-1:0] upd_pc;
    logic                 upd_taken;
    logic [ADDR_BITS-1:0] upd_target;
    logic                 upd_pred_taken;
    logic [ADDR_BITS-1:0] upd_pred_next;
    logic                 upd_mispredict;

    modport master (
        output lk_pc, upd_valid, upd_is_jump, upd_pc, upd_taken,
               upd_target, upd_pred_taken, upd_pred_next,
        input  lk_hit, lk_taken, lk_next_pc, upd_mispredict
    );

    modport slave (
        input  lk_pc, upd_valid, upd_is_jump, upd_pc, upd_taken,
               upd_target, upd_pred_taken, upd_pred_next,
        output lk_hit, lk_taken, lk_next_pc, upd_mispredict
    );

endinterface

// File: rtl/syn_branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
//
// Purpose: IF looks up the next PC combinationally; EX writes resolved
// outcomes back and receives a mispredict flag for redirect/flush.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en           global enable; low holds all state
//   flush        invalidates every entry at the next enabled edge
//   btb          syn_branch_target_buffer_if.slave (lookup + update)
//   stat_branches, stat_mispredicts   only when BTB_STATS_EN is defined
// Configuration macro: BTB_STATS_EN adds the 32-bit statistics counters.
// The interface instance must use the same ADDR_BITS as this module.
module syn_branch_target_buffer
    import syn_branch_target_buffer_pkg::*;
#(
    parameter int ADDR_BITS  = BTB_ADDR_BITS,
    parameter int INDEX_BITS = BTB_INDEX_BITS,
    parameter int CTR_BITS   = BTB_CTR_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic flush,
    syn_branch_target_buffer_if.slave btb
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;

    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT   = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(ctr_weak_t(CTR_BITS));

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [ADDR_BITS-1:0]  target_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;
    logic [CTR_BITS-1:0]   ctr_cur;
    logic [CTR_BITS-1:0]   ctr_nxt;

    assign lk_idx  = btb.lk_pc[INDEX_BITS-1:0];
    assign lk_tag  = btb.lk_pc[ADDR_BITS-1:INDEX_BITS];
    assign upd_idx = btb.upd_pc[INDEX_BITS-1:0];
    assign upd_tag = btb.upd_pc[ADDR_BITS-1:INDEX_BITS];

    // Lookup reads registered state only, so a same-cycle update to the
    // same entry is seen by IF one cycle later (no bypass).
    assign btb.lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign btb.lk_taken   = btb.lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign btb.lk_next_pc = btb.lk_taken ? target_q[lk_idx]
                                         : btb.lk_pc + ADDR_BITS'(1);

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Deliberately not gated by en: EX needs the redirect decision regardless.
    assign btb.upd_mispredict = btb.upd_valid &&
        ((btb.upd_pred_taken != btb.upd_taken) ||
         (btb.upd_taken && (btb.upd_pred_next != btb.upd_target)));

    // Next counter value for a hitting update: jumps force strongly taken,
    // branches move one step toward the outcome and stop at the rails.
    always_comb begin
        ctr_cur = ctr_q[upd_idx];
        ctr_nxt = ctr_cur;
        if (btb.upd_is_jump) begin
            ctr_nxt = CTR_MAX;
        end else if (btb.upd_taken) begin
            if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_BITS'(1);
        end else begin
            if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_BITS'(1);
        end
    end

    // Flush takes priority over a same-cycle update; only valid bits are
    // cleared, the rest of each entry is left as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else if (en) begin
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
            end else if (btb.upd_valid) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= ctr_nxt;
                    if (btb.upd_is_jump || btb.upd_taken)
                        target_q[upd_idx] <= btb.upd_target;
                end else if (btb.upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= btb.upd_target;
                    ctr_q[upd_idx]    <= btb.upd_is_jump ? CTR_MAX : CTR_WEAK_T;
                end
            end
        end
    end

`ifdef BTB_STATS_EN
    // Statistics count every enabled resolved instruction; flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (en && btb.upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (btb.upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/syn_branch_target_buffer.md
Name: syn_branch_target_buffer

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
- Successor to the fixed resolve-in-EX branch scheme of the 5-stage core.
- IF queries it combinationally each cycle to choose the next PC.
- EX updates it with resolved outcomes and receives a mispredict flag so the pipeline can redirect and flush.

Parameters:
- ADDR_BITS, 10, width of word-granular PC (matches IM_ADDR_BIT).
- INDEX_BITS, 4, log2 of entry count (16 entries); must satisfy 1 <= INDEX_BITS < ADDR_BITS.
- CTR_BITS, 2, direction counter width; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global clock enable; when low, all state holds.
- flush  in  1  synchronous invalidate of all entries.
- lk_pc  in  ADDR_BITS  IF-stage PC (word address).
- lk_hit  out  1  valid entry with matching tag.
- lk_taken  out  1  predicted taken.
- lk_next_pc  out  ADDR_BITS  lk_taken ? stored target : lk_pc+1 (wraps modulo 2^ADDR_BITS).
- upd_valid  in  1  EX holds a resolved control-flow instruction this cycle.
- upd_is_jump  in  1  unconditional jump (j/jal/jr); otherwise conditional branch.
- upd_pc  in  ADDR_BITS  PC of the resolved instruction.
- upd_taken  in  1  actual direction (forced 1 for jumps by the caller).
- upd_target  in  ADDR_BITS  actual target.
- upd_pred_taken  in  1  lk_taken piped from IF.
- upd_pred_next  in  ADDR_BITS  lk_next_pc piped from IF.
- upd_mispredict  out  1  combinational: upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_next != upd_target)).

Behaviour:
- Index = pc[INDEX_BITS-1:0]; tag = pc[ADDR_BITS-1:INDEX_BITS]. Each entry holds valid, tag, target, ctr.
- Lookup is purely combinational.
  - lk_hit = valid[idx] && tag match.
  - lk_taken = lk_hit && ctr MSB.
  - On a miss, lk_next_pc = lk_pc+1.
- Reset (async, rst_n low):
  - All valid = 0; every ctr = 2^(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS=1).
  - Tags and targets = 0.
  - Outputs follow combinationally: lk_hit=0, lk_taken=0, lk_next_pc=lk_pc+1.
- Update at clock edge, gated by en && upd_valid:
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not (no wrap past max or 0). Target overwritten when taken.
  - Hit, jump: ctr set to all-ones; target overwritten.
  - Miss, taken (branch or jump): allocate, replacing any occupant. Set valid=1, tag, target. ctr = all-ones for a jump, 2^(CTR_BITS-1) (weakly taken) for a branch.
  - Miss, not taken: no state change.
- flush with en high: all valid cleared at the next edge. Counters, tags and targets are untouched.
- flush together with an update in the same cycle: flush wins and no entry is written.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state. There is no bypass; the new state is visible next cycle.
- en low: no state change, including flush and stats. Combinational outputs stay live.
- Latency: prediction 0 cycles; update visible 1 cycle after the edge.
- upd_mispredict is independent of en (pure combinational).

Optional Feature:
- Macro BTB_STATS_EN.
- Defined:
  - Adds outputs stat_branches (32) and stat_mispredicts (32), both reset to 0.
  - On en && upd_valid, stat_branches +1; stat_mispredicts +1 when upd_mispredict. Both wrap modulo 2^32.
  - Both counters are unaffected by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (Core.vh style):
  - Default ADDR_BITS tied to IM_ADDR_BIT.
  - BTB_INDEX_BITS and BTB_CTR_BITS defaults.
  - Counter init constants (weak-NT and weak-T expressions).
- Sub-module sat_counter (CTR_BITS param; inc/dec/set-max/init inputs).
  - Instantiated per entry via a generate loop.
  - Alternatively a shared next-value function for the single updated entry.

Test Plan:
- Reset then lk_pc=0x010 -> lk_hit=0, lk_taken=0, lk_next_pc=0x011; upd_mispredict=0 with upd_valid=0.
- Branch update pc=0x010 taken, target=0x040, pred_taken=0 -> upd_mispredict=1. Next cycle lookup 0x010 gives hit=1, taken=1 (ctr=2), next_pc=0x040.
- Two not-taken updates on pc=0x010 -> ctr 2→1→0, lk_taken=0, lk_hit=1. A third not-taken update leaves ctr at 0 (saturation). Four taken updates -> ctr saturates at 3.
- Alias pc=0x020 (same index 0, different tag), taken jump to 0x100 -> entry replaced with ctr=3. Lookup 0x010 then misses; lookup 0x020 gives next_pc=0x100.
- flush asserted with a simultaneous taken update to pc=0x005 -> all lookups miss next cycle, including 0x005. With en=0, an update has no effect.
- Target mismatch: pred_taken=1, pred_next=0x040, actual taken to 0x044 -> upd_mispredict=1. With BTB_STATS_EN defined, stat_mispredicts increments by 1 and stat_branches increments by 1.
